// File: rtl/jtag_load_ctrl.sv
// Sequences whole-image LOAD / DUMP / SWAP transfers between a host word stream
// and a RAM scan chain, and blocks CPU writes while the chain is in use.
module jtag_load_ctrl #(
   parameter int WORDS = 512,
   parameter int CW    = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Start,
   input  logic [1:0]  Mode,
   input  logic        Abort,
   input  logic [31:0] Sin,
   input  logic        Sin_valid,
   output logic        Sin_ready,
   output logic [31:0] Sout,
   output logic        Sout_valid,
   input  logic        Sout_ready,
   output logic        Busy,
   output logic        Done,
   output logic        Aborted,
   output logic        Jen,
   output logic [31:0] Jin,
   input  logic [31:0] Jout,
   input  logic        Cpu_wen,
   output logic        Wen,
   output logic        Cpu_stall
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

   localparam logic [1:0]    MODE_LOAD = 2'b00;
   localparam logic [1:0]    MODE_DUMP = 2'b01;
   localparam logic [1:0]    MODE_SWAP = 2'b10;
   localparam logic [1:0]    MODE_RSVD = 2'b11;
   localparam logic [CW-1:0] LAST      = CW'(WORDS - 1);

   state_t        state, state_next;
   logic [CW-1:0] count, count_next;
   logic [1:0]    mode, mode_next;
   logic          abort_pulse, abort_pulse_next;

   logic uses_in, uses_out, in_ok, out_ok, in_shift;

   assign uses_in  = (mode == MODE_LOAD) || (mode == MODE_SWAP);
   assign uses_out = (mode == MODE_DUMP) || (mode == MODE_SWAP);
   assign in_ok    = ~uses_in  | Sin_valid;
   assign out_ok   = ~uses_out | Sout_ready;
   assign in_shift = (state == SHIFT);

   // Purely combinational so every host transfer lands on the same edge as its shift.
   assign Jen        = in_shift & in_ok & out_ok & ~Abort;
   assign Sin_ready  = in_shift & uses_in & out_ok & ~Abort;
   assign Sout_valid = in_shift & uses_out & in_ok & ~Abort;

   // DUMP feeds the tail back into the head so the image survives a full pass.
   assign Jin  = (mode == MODE_DUMP) ? Jout : Sin;
   assign Sout = Jout;

   assign Busy      = (state != IDLE);
   assign Done      = (state == FIN);
   assign Aborted   = abort_pulse;
   assign Wen       = Cpu_wen & ~Busy;
   assign Cpu_stall = Busy & Cpu_wen;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         mode        <= MODE_LOAD;
         abort_pulse <= 1'b0;
      end else begin
         state       <= state_next;
         count       <= count_next;
         mode        <= mode_next;
         abort_pulse <= abort_pulse_next;
      end
   end

   always_comb begin
      state_next       = state;
      count_next       = count;
      mode_next        = mode;
      abort_pulse_next = 1'b0;
      case (state)
         IDLE: begin
            if (Start && (Mode != MODE_RSVD)) begin
               state_next = SHIFT;
               count_next = '0;
               mode_next  = Mode;
            end
         end
         SHIFT: begin
            // Abort takes priority over a shift qualifying in the same cycle.
            if (Abort) begin
               state_next       = IDLE;
               abort_pulse_next = 1'b1;
            end else if (Jen) begin
               count_next = count + 1'b1;
               if (count == LAST) begin
                  state_next = FIN;
               end
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_jtag_load_ctrl.sv
// Bench for jtag_load_ctrl: a behavioural scan chain plus a queue model of the
// RAM image in shift-out order, exercised with directed and random host stalls.
module tb_jtag_load_ctrl;
   localparam int WORDS = 512;
   localparam int CW    = 10;
   localparam logic [1:0] LOAD = 2'b00, DUMP = 2'b01, SWAP = 2'b10, RSVD = 2'b11;

   logic clk = 1'b0, rst_n = 1'b0;
   logic Start = 1'b0, Abort = 1'b0, Sin_valid = 1'b0, Sout_ready = 1'b0, Cpu_wen = 1'b0;
   logic [1:0]  Mode = 2'b00;
   logic [31:0] Sin = '0;
   logic [31:0] Sout, Jin, Jout;
   logic Sin_ready, Sout_valid, Busy, Done, Aborted, Jen, Wen, Cpu_stall;

   int total = 0;
   int bad = 0;

   logic [31:0] chain [WORDS] = '{default: 32'h0};
   logic [31:0] send_words [WORDS];
   logic [31:0] image[$];
   logic [31:0] exp_out[$];
   logic [31:0] got[$];

   // Results recorded by run_op for the test tasks to judge.
   int n_jen, last_jen, done_cyc, done_cnt, end_cyc, abort_cyc, viol;
   bit timed_out, reset_hit, aborted_end, aborted_after, wen_end, stall_end;
   logic [6:0] rst_obs;
   string viol_msg;

   jtag_load_ctrl #(.WORDS(WORDS), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .Start(Start), .Mode(Mode), .Abort(Abort),
      .Sin(Sin), .Sin_valid(Sin_valid), .Sin_ready(Sin_ready),
      .Sout(Sout), .Sout_valid(Sout_valid), .Sout_ready(Sout_ready),
      .Busy(Busy), .Done(Done), .Aborted(Aborted), .Jen(Jen), .Jin(Jin), .Jout(Jout),
      .Cpu_wen(Cpu_wen), .Wen(Wen), .Cpu_stall(Cpu_stall)
   );

   always #5 clk = ~clk;

   // RAM scan chain: chain[0] is the head, chain[WORDS-1] the tail.
   assign Jout = chain[WORDS-1];
   always @(posedge clk) begin
      if (Jen === 1'b1) begin
         for (int i = WORDS - 1; i > 0; i--) chain[i] <= chain[i-1];
         chain[0] <= Jin;
      end
   end

   // n shifts: oldest word leaves the tail (seen by host unless LOAD), and the
   // new word (recirculated word for DUMP) enters at the back of the order.
   function automatic void apply_model(input logic [1:0] m, input int n);
      logic [31:0] old;
      exp_out.delete();
      for (int i = 0; i < n; i++) begin
         old = image.pop_front();
         if (m != LOAD) exp_out.push_back(old);
         image.push_back((m == DUMP) ? old : send_words[i]);
      end
   endfunction

   task automatic run_op(input logic [1:0] m, input int stall, input int abort_at,
                         input int reset_at, input bit noise, input bit start_now);
      int k, cyc, hold;
      bit exp_shift, in_ok, out_ok, uin, uout, jen_obs;
      logic [8:0] obs, exp;
      n_jen = 0; last_jen = -1; done_cyc = -1; done_cnt = 0; end_cyc = -1; abort_cyc = -1;
      viol = 0; viol_msg = ""; timed_out = 0; reset_hit = 0; got.delete();
      k = 0; cyc = 0; hold = 0;
      uin = (m != DUMP); uout = (m != LOAD);
      if (!start_now) @(negedge clk);
      Start = 1'b1; Mode = m;
      @(negedge clk);
      Start = 1'b0;
      forever begin
         if (Busy !== 1'b1) begin end_cyc = cyc; break; end
         if (cyc > 4 * WORDS + 20) begin timed_out = 1; break; end
         Sin = (m == DUMP) ? $urandom : ((k < WORDS) ? send_words[k] : 32'hDEAD_BEEF);
         case (stall)
            1:       begin Sin_valid = 1'b1; Sout_ready = (cyc % 2 == 0); end
            2:       begin Sin_valid = !(k == 100 && hold < 3); Sout_ready = 1'b1; end
            3:       begin Sin_valid = ($urandom_range(0, 3) != 0); Sout_ready = ($urandom_range(0, 3) != 0); end
            default: begin Sin_valid = 1'b1; Sout_ready = 1'b1; end
         endcase
         Abort = (k == abort_at);
         if (noise) begin Start = $urandom_range(0, 1); Mode = 2'($urandom); end
         #1;
         if (k == reset_at) begin
            rst_n = 1'b0;
            #1;
            rst_obs = {Jen, Sin_ready, Sout_valid, Busy, Cpu_stall, Done, Aborted};
            reset_hit = 1;
            break;
         end
         exp_shift = (k < WORDS);
         in_ok  = uin  ? Sin_valid  : 1'b1;
         out_ok = uout ? Sout_ready : 1'b1;
         obs = {Jen, Sin_ready, Sout_valid, Done, Aborted, Wen, Cpu_stall, (Sout === Jout),
                (Jen !== 1'b1) || (Jin === ((m == DUMP) ? Jout : Sin))};
         exp = {exp_shift & in_ok & out_ok & ~Abort, exp_shift & uin & out_ok & ~Abort,
                exp_shift & uout & in_ok & ~Abort, !exp_shift, 1'b0, 1'b0, Cpu_wen, 1'b1, 1'b1};
         if (obs !== exp) begin
            viol++;
            if (viol == 1) viol_msg = $sformatf("cycle %0d k %0d got %b required %b", cyc, k, obs, exp);
         end
         jen_obs = (Jen === 1'b1);
         if (jen_obs) begin n_jen++; last_jen = cyc; end
         if (Done === 1'b1) begin done_cnt++; done_cyc = cyc; end
         if (Abort && exp_shift) abort_cyc = cyc;
         if (Sout_valid === 1'b1 && Sout_ready) got.push_back(Sout);
         if (stall == 2 && k == 100 && hold < 3) hold++;
         @(negedge clk);
         if (jen_obs) k++;
         cyc++;
      end
      Start = 1'b0; Abort = 1'b0; Sin_valid = 1'b0; Sout_ready = 1'b0;
      if (!reset_hit && !timed_out) begin
         aborted_end = Aborted; wen_end = Wen; stall_end = Cpu_stall;
         @(negedge clk);
         aborted_after = Aborted;
      end
   endtask

   task automatic test_reset;
      Cpu_wen = 1'b1;
      #2;
      total++;
      if ({Busy, Jen, Sin_ready, Sout_valid, Cpu_stall, Done, Aborted, Wen} !== 8'b0000_0001) begin
         bad++;
         $display("FAIL reset_outputs: got %b required 00000001",
                  {Busy, Jen, Sin_ready, Sout_valid, Cpu_stall, Done, Aborted, Wen});
      end
      @(negedge clk);
      rst_n = 1'b1;
      Start = 1'b1; Mode = RSVD;
      @(negedge clk);
      Start = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({Busy, Done, Aborted} !== 3'b000) begin
         bad++;
         $display("FAIL reserved_mode: Busy/Done/Aborted got %b required 000", {Busy, Done, Aborted});
      end
      $display("reset + reserved-mode start checked");
   endtask

   task automatic test_load;
      for (int i = 0; i < WORDS; i++) send_words[i] = 32'h1000_0000 + 32'(i);
      Cpu_wen = 1'b1;
      run_op(LOAD, 0, -1, -1, 0, 0);
      apply_model(LOAD, WORDS);
      total++;
      if (timed_out || n_jen != WORDS || last_jen != WORDS - 1) begin
         bad++;
         $display("FAIL load_jen: timeout %0d jen cycles %0d last %0d required 0 %0d %0d",
                  timed_out, n_jen, last_jen, WORDS, WORDS - 1);
      end
      total++;
      if (done_cnt != 1 || done_cyc != last_jen + 1 || end_cyc != done_cyc + 1) begin
         bad++;
         $display("FAIL load_done: done count %0d at %0d end %0d required 1 at %0d end %0d",
                  done_cnt, done_cyc, end_cyc, last_jen + 1, last_jen + 2);
      end
      total++;
      if (viol != 0) begin bad++; $display("FAIL load_rules: %0d violations, first %s", viol, viol_msg); end
      total++;
      if ({wen_end, stall_end, aborted_end} !== 3'b100) begin
         bad++;
         $display("FAIL load_wen_release: Wen/Cpu_stall/Aborted got %b required 100",
                  {wen_end, stall_end, aborted_end});
      end
      Cpu_wen = 1'b0;
      $display("LOAD: %0d shifts, done at cycle %0d", n_jen, done_cyc);
   endtask

   task automatic test_dump(input string name, input int stall);
      int first;
      run_op(DUMP, stall, -1, -1, 0, 0);
      apply_model(DUMP, WORDS);
      first = -1;
      if (got.size() == exp_out.size())
         foreach (got[i]) if (first < 0 && got[i] !== exp_out[i]) first = i;
      total++;
      if (timed_out || got.size() != exp_out.size() || first >= 0) begin
         bad++;
         $display("FAIL %s_stream: got %0d words (first diff %0d) required %0d words", name,
                  got.size(), first, exp_out.size());
      end
      total++;
      if (viol != 0 || n_jen != WORDS || done_cnt != 1) begin
         bad++;
         $display("FAIL %s_rules: viol %0d jen %0d done %0d required 0 %0d 1 (%s)", name,
                  viol, n_jen, done_cnt, WORDS, viol_msg);
      end
      $display("%s: %0d words read out", name, got.size());
   endtask

   task automatic test_swap;
      int first;
      for (int i = 0; i < WORDS; i++) send_words[i] = 32'hA5A5_0000 + 32'(i);
      run_op(SWAP, 2, -1, -1, 0, 0);
      apply_model(SWAP, WORDS);
      first = -1;
      if (got.size() == exp_out.size())
         foreach (got[i]) if (first < 0 && got[i] !== exp_out[i]) first = i;
      total++;
      if (timed_out || got.size() != exp_out.size() || first >= 0) begin
         bad++;
         $display("FAIL swap_old_image: got %0d words (first diff %0d) required %0d",
                  got.size(), first, exp_out.size());
      end
      total++;
      if (viol != 0 || n_jen != WORDS || last_jen != WORDS + 2) begin
         bad++;
         $display("FAIL swap_stall: viol %0d jen %0d last %0d required 0 %0d %0d (%s)",
                  viol, n_jen, last_jen, WORDS, WORDS + 2, viol_msg);
      end
      $display("SWAP: %0d shifts, last at cycle %0d", n_jen, last_jen);
      test_dump("dump_after_swap", 0);
   endtask

   task automatic test_abort(input string name, input logic [1:0] m, input int at);
      for (int i = 0; i < WORDS; i++) send_words[i] = $urandom;
      run_op(m, 3, at, -1, 0, 0);
      apply_model(m, at);
      total++;
      if (timed_out || n_jen != at || done_cnt != 0 || abort_cyc < 0 || end_cyc != abort_cyc + 1) begin
         bad++;
         $display("FAIL %s_stop: jen %0d done %0d abort cyc %0d end %0d required %0d 0 >=0 %0d",
                  name, n_jen, done_cnt, abort_cyc, end_cyc, at, abort_cyc + 1);
      end
      total++;
      if ({aborted_end, aborted_after} !== 2'b10 || viol != 0) begin
         bad++;
         $display("FAIL %s_pulse: Aborted got %b viol %0d required 10 and 0 (%s)", name,
                  {aborted_end, aborted_after}, viol, viol_msg);
      end
      $display("%s: aborted after %0d shifts", name, n_jen);
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < WORDS; i++) send_words[i] = $urandom;
      Cpu_wen = 1'b1;
      run_op(LOAD, 0, -1, 200, 0, 0);
      apply_model(LOAD, 200);
      total++;
      if (!reset_hit || rst_obs !== 7'b0) begin
         bad++;
         $display("FAIL reset_mid_outputs: hit %0d Jen/Srdy/Svld/Busy/Stall/Done/Ab got %b required 0000000",
                  reset_hit, rst_obs);
      end
      Cpu_wen = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < WORDS; i++) send_words[i] = $urandom;
      run_op(LOAD, 3, -1, -1, 0, 1);
      apply_model(LOAD, WORDS);
      total++;
      if (timed_out || n_jen != WORDS || done_cnt != 1 || viol != 0) begin
         bad++;
         $display("FAIL reset_mid_restart: jen %0d done %0d viol %0d required %0d 1 0 (%s)",
                  n_jen, done_cnt, viol, WORDS, viol_msg);
      end
      $display("reset mid-shift, restart performed %0d shifts", n_jen);
      test_dump("dump_after_reset", 3);
   endtask

   task automatic test_back_to_back;
      logic [1:0] m;
      int first;
      for (int r = 0; r < 4; r++) begin
         m = 2'($urandom_range(0, 2));
         for (int i = 0; i < WORDS; i++) send_words[i] = $urandom;
         run_op(m, 3, -1, -1, 1, 0);
         apply_model(m, WORDS);
         first = -1;
         if (got.size() == exp_out.size())
            foreach (got[i]) if (first < 0 && got[i] !== exp_out[i]) first = i;
         total++;
         if (timed_out || got.size() != exp_out.size() || first >= 0 || n_jen != WORDS
             || done_cnt != 1 || viol != 0) begin
            bad++;
            $display("FAIL b2b_%0d: mode %0d words %0d/%0d diff %0d jen %0d done %0d viol %0d (%s)",
                     r, m, got.size(), exp_out.size(), first, n_jen, done_cnt, viol, viol_msg);
         end
         $display("back-to-back op %0d mode %0d: %0d shifts", r, m, n_jen);
      end
      test_dump("dump_final", 1);
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++) image.push_back(32'h0);
      test_reset();
      test_load();
      test_dump("dump1", 1);
      test_dump("dump2", 1);
      test_swap();
      test_abort("abort37", SWAP, 37);
      test_abort("abort_last", DUMP, WORDS - 1);
      test_dump("dump_after_abort", 0);
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
